// File: rtl/hiscore_ram_bridge_if.sv
// Bus bundle between the hiscore RAM bridge and its surroundings:
// hiscore engine side, game CPU side and the single-port work RAM.
// The bridge uses the slave view; the environment uses the master view.
interface hiscore_ram_bridge_if #(
  parameter int AW = 10
);
  logic          hs_pause;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_data;
  logic          hs_write;
  logic [7:0]    hs_din;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic          cpu_we;
  logic          cpu_idle;
  logic          cpu_pause_req;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic          ram_we;
  logic [7:0]    ram_q;
  logic          ram_sel;
  logic          fifo_overflow;
  logic          grant_timeout;

  modport slave (
    input  hs_pause, hs_addr, hs_data, hs_write,
    input  cpu_addr, cpu_dout, cpu_we, cpu_idle,
    input  ram_q,
    output hs_din, cpu_pause_req, ram_addr, ram_dout, ram_we, ram_sel,
    output fifo_overflow, grant_timeout
  );

  modport master (
    output hs_pause, hs_addr, hs_data, hs_write,
    output cpu_addr, cpu_dout, cpu_we, cpu_idle,
    output ram_q,
    input  hs_din, cpu_pause_req, ram_addr, ram_dout, ram_we, ram_sel,
    input  fifo_overflow, grant_timeout
  );
endinterface

// File: rtl/hiscore_ram_bridge.sv
// Hiscore RAM bridge: arbitrates the game's single-port work RAM between
// the CPU and the hiscore engine. Ownership is taken only after the CPU
// acknowledges a pause (or a timeout forces it). Hiscore writes are queued
// in a small FIFO so none are lost while waiting; reads are issued only
// when the FIFO is empty, so they never overtake a queued write.
module hiscore_ram_bridge #(
  parameter int          AW        = 10,
  parameter int          FIFO_LOG2 = 3,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic           clk,
  input  logic           reset,
  hiscore_ram_bridge_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int EW    = AW + 8;
  localparam logic [FIFO_LOG2:0] FULL_CNT = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t               r_state;
  logic [EW-1:0]        r_fifoMem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wrPtr;
  logic [FIFO_LOG2-1:0] r_rdPtr;
  logic [FIFO_LOG2:0]   r_count;
  logic                 r_overflow;
  logic                 r_timeout;
  logic                 r_pauseReq;
  logic                 r_ramSel;
  logic [AW-1:0]        r_hsRa;
  logic [7:0]           r_hsRd;
  logic                 r_hsRwe;
  logic                 r_rdPend;
  logic [7:0]           r_hsDin;
  logic                 r_idleS1;
  logic                 r_idleS2;
  logic                 r_idleS3;
  logic [15:0]          r_toCnt;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_reqSrc;
  logic [EW-1:0]        w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = (r_state == ST_GRANT) && !w_empty;
  assign w_push   = bus.hs_write && (!w_full || w_pop);
  assign w_drop   = bus.hs_write && w_full && !w_pop;
  assign w_reqSrc = bus.hs_pause || bus.hs_write || !w_empty;
  assign w_head   = r_fifoMem[r_rdPtr];

  // RAM port mux: CPU owns the RAM unless the registered select hands it over
  assign bus.ram_addr = r_ramSel ? r_hsRa  : bus.cpu_addr;
  assign bus.ram_dout = r_ramSel ? r_hsRd  : bus.cpu_dout;
  assign bus.ram_we   = r_ramSel ? r_hsRwe : bus.cpu_we;

  assign bus.cpu_pause_req = r_pauseReq;
  assign bus.ram_sel       = r_ramSel;
  assign bus.hs_din        = r_hsDin;
  assign bus.fifo_overflow = r_overflow;
  assign bus.grant_timeout = r_timeout;

  // FIFO storage; flushing is done by resetting the pointers, not the array
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= {bus.hs_addr, bus.hs_data};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Ownership FSM with registered pause/select and hiscore-side RAM signals
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pauseReq <= 1'b0;
      r_ramSel   <= 1'b0;
      r_hsRa     <= '0;
      r_hsRd     <= '0;
      r_hsRwe    <= 1'b0;
      r_timeout  <= 1'b0;
      r_idleS1   <= 1'b0;
      r_idleS2   <= 1'b0;
      r_idleS3   <= 1'b0;
      r_toCnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pauseReq <= 1'b0;
          r_ramSel   <= 1'b0;
          r_hsRwe    <= 1'b0;
          r_idleS1   <= 1'b0;
          r_idleS2   <= 1'b0;
          r_idleS3   <= 1'b0;
          r_toCnt    <= '0;
          if (w_reqSrc) begin
            r_state    <= ST_REQ;
            r_pauseReq <= 1'b1;
          end
        end
        ST_REQ: begin
          r_idleS1 <= bus.cpu_idle;
          r_idleS2 <= r_idleS1;
          r_idleS3 <= r_idleS2;
          r_toCnt  <= r_toCnt + 16'd1;
          if (!w_reqSrc) begin
            r_state    <= ST_IDLE;
            r_pauseReq <= 1'b0;
          end else if (r_idleS2 && r_idleS3) begin
            r_state  <= ST_GRANT;
            r_ramSel <= 1'b1;
          end else if (r_toCnt + 16'd1 == TIMEOUT) begin
            r_state   <= ST_GRANT;
            r_ramSel  <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        ST_GRANT: begin
          r_idleS1 <= 1'b0;
          r_idleS2 <= 1'b0;
          r_idleS3 <= 1'b0;
          r_toCnt  <= '0;
          if (!w_empty) begin
            r_hsRa  <= w_head[EW-1:8];
            r_hsRd  <= w_head[7:0];
            r_hsRwe <= 1'b1;
          end else begin
            r_hsRa  <= bus.hs_addr;
            r_hsRwe <= 1'b0;
          end
          if (!bus.hs_pause && !bus.hs_write && w_empty) begin
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_hsRwe    <= 1'b0;
          r_ramSel   <= 1'b0;
          r_pauseReq <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Readback: capture ram_q one cycle after a hiscore-owned read access
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPend <= 1'b0;
      r_hsDin  <= '0;
    end else begin
      r_rdPend <= r_ramSel && !r_hsRwe;
      if (r_rdPend) r_hsDin <= bus.ram_q;
    end
  end

endmodule

// File: tb/tb_hiscore_ram_bridge.sv
// Directed testbench for hiscore_ram_bridge with a 1-cycle synchronous RAM
// model and a log of every hiscore-side RAM write.
module tb_hiscore_ram_bridge;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   logBase;

  logic [7:0] ramMem [1024];
  logic [9:0] logAddr [$];
  logic [7:0] logData [$];
  int         logCyc  [$];

  logic [9:0] expAddr3 [3];
  logic [7:0] expData3 [3];

  hiscore_ram_bridge_if #(.AW(10)) bus ();

  hiscore_ram_bridge #(
    .AW(10),
    .FIFO_LOG2(3),
    .TIMEOUT(16'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model plus a log of writes issued while the hiscore side owns RAM
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_we) ramMem[bus.ram_addr] <= bus.ram_dout;
    bus.ram_q <= ramMem[bus.ram_addr];
    if (bus.ram_we && bus.ram_sel) begin
      logAddr.push_back(bus.ram_addr);
      logData.push_back(bus.ram_dout);
      logCyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic pause, input logic wr,
                               input logic [9:0] addr, input logic [7:0] data,
                               input logic idle);
    bus.hs_pause = pause;
    bus.hs_write = wr;
    bus.hs_addr  = addr;
    bus.hs_data  = data;
    bus.cpu_idle = idle;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    expAddr3    = '{10'h010, 10'h011, 10'h012};
    expData3    = '{8'hA5, 8'h5A, 8'hFF};
    reset       = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_dout = '0;
    bus.cpu_we   = 1'b0;
    applyStimulus(1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
    tick(2);

    // Reset state
    checkOutput("rst_ram_sel", 32'(bus.ram_sel), 32'd0);
    checkOutput("rst_pause_req", 32'(bus.cpu_pause_req), 32'd0);
    checkOutput("rst_hs_din", 32'(bus.hs_din), 32'h00);
    checkOutput("rst_overflow", 32'(bus.fifo_overflow), 32'd0);
    checkOutput("rst_timeout", 32'(bus.grant_timeout), 32'd0);
    reset = 1'b0;

    // CPU pass-through, also seeding RAM for the later readback
    bus.cpu_addr = 10'h123;
    bus.cpu_dout = 8'h77;
    bus.cpu_we   = 1'b1;
    #1;
    checkOutput("cpu_ram_addr", 32'(bus.ram_addr), 32'h123);
    checkOutput("cpu_ram_we", 32'(bus.ram_we), 32'd1);
    checkOutput("cpu_ram_dout", 32'(bus.ram_dout), 32'h77);
    checkOutput("cpu_ram_sel", 32'(bus.ram_sel), 32'd0);
    checkOutput("cpu_pause_req", 32'(bus.cpu_pause_req), 32'd0);
    tick(1);
    bus.cpu_addr = 10'h200;
    bus.cpu_dout = 8'h3C;
    tick(1);
    bus.cpu_addr = 10'h201;
    bus.cpu_dout = 8'hC3;
    tick(1);
    bus.cpu_we = 1'b0;

    // Pause handshake with cpu_idle already high
    applyStimulus(1'b1, 1'b0, 10'h000, 8'h00, 1'b1);
    tick(1);
    checkOutput("hs_pause_req", 32'(bus.cpu_pause_req), 32'd1);
    checkOutput("hs_sel_early", 32'(bus.ram_sel), 32'd0);
    tick(3);
    checkOutput("hs_sel_3", 32'(bus.ram_sel), 32'd0);
    tick(1);
    checkOutput("hs_sel_4", 32'(bus.ram_sel), 32'd1);

    // Pipelined readback: 0x200 at N, 0x201 at N+1
    bus.hs_addr = 10'h200;
    tick(1);
    bus.hs_addr = 10'h201;
    #1;
    checkOutput("rd_ram_addr", 32'(bus.ram_addr), 32'h200);
    checkOutput("rd_ram_we", 32'(bus.ram_we), 32'd0);
    tick(2);
    checkOutput("rd_din_200", 32'(bus.hs_din), 32'h3C);
    tick(1);
    checkOutput("rd_din_201", 32'(bus.hs_din), 32'hC3);

    // Release
    bus.hs_pause = 1'b0;
    tick(2);
    checkOutput("rel_ram_sel", 32'(bus.ram_sel), 32'd0);
    checkOutput("rel_pause_req", 32'(bus.cpu_pause_req), 32'd0);

    // Three buffered writes issued from IDLE
    logBase = logAddr.size();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, expAddr3[i], expData3[i], 1'b1);
      tick(1);
    end
    applyStimulus(1'b0, 1'b0, 10'h000, 8'h00, 1'b1);
    tick(15);
    checkOutput("wr3_count", 32'(logAddr.size() - logBase), 32'd3);
    if (logAddr.size() - logBase == 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("wr3_addr%0d", i), 32'(logAddr[logBase+i]), 32'(expAddr3[i]));
        checkOutput($sformatf("wr3_data%0d", i), 32'(logData[logBase+i]), 32'(expData3[i]));
      end
      checkOutput("wr3_back2back", 32'(logCyc[logBase+2] - logCyc[logBase]), 32'd2);
    end
    checkOutput("wr3_sel_idle", 32'(bus.ram_sel), 32'd0);

    // Overflow: nine writes into an eight-entry FIFO while CPU is busy
    logBase = logAddr.size();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 10'(10'h020 + i), 8'(8'h10 + i), 1'b0);
      tick(1);
    end
    applyStimulus(1'b0, 1'b0, 10'h000, 8'h00, 1'b1);
    #1;
    checkOutput("ovf_flag", 32'(bus.fifo_overflow), 32'd1);
    checkOutput("ovf_no_grant", 32'(bus.ram_sel), 32'd0);
    tick(25);
    checkOutput("ovf_count", 32'(logAddr.size() - logBase), 32'd8);
    if (logAddr.size() - logBase == 8) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("ovf_addr%0d", i), 32'(logAddr[logBase+i]), 32'(10'h020 + i));
        checkOutput($sformatf("ovf_data%0d", i), 32'(logData[logBase+i]), 32'(8'h10 + i));
      end
    end
    checkOutput("ovf_sticky", 32'(bus.fifo_overflow), 32'd1);
    checkOutput("ovf_no_timeout", 32'(bus.grant_timeout), 32'd0);
    checkOutput("ovf_released", 32'(bus.cpu_pause_req), 32'd0);

    // Forced grant after 16 REQ cycles with cpu_idle stuck low
    applyStimulus(1'b1, 1'b0, 10'h000, 8'h00, 1'b0);
    tick(16);
    checkOutput("to_sel_15", 32'(bus.ram_sel), 32'd0);
    checkOutput("to_flag_15", 32'(bus.grant_timeout), 32'd0);
    tick(1);
    checkOutput("to_sel_16", 32'(bus.ram_sel), 32'd1);
    checkOutput("to_flag_16", 32'(bus.grant_timeout), 32'd1);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 10'(10'h040 + i), 8'(8'hE0 + i), 1'b0);
      tick(1);
    end
    applyStimulus(1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
    reset = 1'b1;
    tick(1);
    checkOutput("mid_rst_sel", 32'(bus.ram_sel), 32'd0);
    checkOutput("mid_rst_pause", 32'(bus.cpu_pause_req), 32'd0);
    checkOutput("mid_rst_din", 32'(bus.hs_din), 32'h00);
    checkOutput("mid_rst_ovf", 32'(bus.fifo_overflow), 32'd0);
    checkOutput("mid_rst_to", 32'(bus.grant_timeout), 32'd0);
    checkOutput("mid_rst_we", 32'(bus.ram_we), 32'd0);
    checkOutput("mid_rst_addr", 32'(bus.ram_addr), 32'h201);
    logBase = logAddr.size();
    reset = 1'b0;
    tick(8);
    checkOutput("post_rst_pause", 32'(bus.cpu_pause_req), 32'd0);
    checkOutput("post_rst_sel", 32'(bus.ram_sel), 32'd0);
    checkOutput("post_rst_nowr", 32'(logAddr.size() - logBase), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hiscore_ram_bridge.md
Name: hiscore_ram_bridge

Overview:
Downstream stage of the hiscore save/restore block. It arbitrates the game's single-port work RAM between the game CPU and the hiscore engine. It requests a CPU pause and waits for an idle acknowledge before taking the RAM. Hiscore writes are buffered in a small FIFO and drained into RAM; hiscore reads are returned on a fixed-latency data path that feeds the engine's readback/compare input.

Parameters:
AW, 10, RAM address width (matches the hiscore engine's ADDRESSWIDTH)
FIFO_LOG2, 3, log2 of write-FIFO depth (default 8 entries)
TIMEOUT, 16'hFFFF, REQ-state cycles before a forced grant

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hs_pause  in  1  hiscore engine wants RAM ownership (upload/dump active)
hs_addr  in  AW  hiscore RAM address
hs_data  in  8  hiscore write data
hs_write  in  1  hiscore write strobe, 1 cycle = 1 byte
hs_din  out  8  readback data to hiscore engine (its ioctl_din source)
cpu_addr  in  AW  CPU RAM address
cpu_dout  in  8  CPU write data
cpu_we  in  1  CPU write enable
cpu_idle  in  1  CPU acknowledges pause (halted at a safe boundary)
cpu_pause_req  out  1  pause request to CPU
ram_addr  out  AW  RAM address
ram_dout  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_q  in  8  RAM read data, 1-cycle synchronous read
ram_sel  out  1  1 = hiscore owns RAM
fifo_overflow  out  1  sticky: a write was dropped because the FIFO was full
grant_timeout  out  1  sticky: grant was forced after TIMEOUT

Behaviour:
- Reset (any cycle, including mid-drain):
  - FSM returns to IDLE; FIFO is flushed; timeout counter and idle-sync are cleared.
  - All outputs are 0 from the next edge: cpu_pause_req, ram_sel, hs_din, both sticky flags; registered hiscore-side addr/data/we.
- Output mux: ram_addr/ram_dout/ram_we are combinational.
  - ram_sel=0: they pass cpu_addr/cpu_dout/cpu_we.
  - ram_sel=1: they pass internal registered signals hs_ra/hs_rd/hs_rwe.
  - ram_sel is registered.
- FIFO: write-only buffer, FIFO_LOG2+1-bit count.
  - Push: hs_write=1 pushes {hs_addr, hs_data}. This happens in every state, including IDLE/REQ, so writes are buffered until grant.
  - Push when full without a same-cycle pop: entry dropped, fifo_overflow set.
  - Push and pop in the same cycle are allowed at any occupancy; count is unchanged.
  - Pointers wrap modulo depth.
- States:
  - IDLE: ram_sel=0, cpu_pause_req=0. If hs_pause or hs_write or FIFO non-empty -> REQ.
  - REQ: cpu_pause_req=1.
    - cpu_idle is sampled through a 2-flop sync; a synced cpu_idle high for 2 consecutive cycles -> GRANT.
    - Timeout counter increments each cycle; on reaching TIMEOUT -> GRANT and set grant_timeout.
    - If all request sources drop before grant -> IDLE.
  - GRANT: ram_sel=1, cpu_pause_req=1.
    - Writes have priority. FIFO non-empty: pop head into hs_ra/hs_rd with hs_rwe=1, one byte per cycle.
    - FIFO empty: hs_ra<=hs_addr, hs_rwe=0.
    - Exit when hs_pause=0, hs_write=0 and FIFO empty, all in the same cycle -> RELEASE.
  - RELEASE: hs_rwe=0, ram_sel<=0, cpu_pause_req<=0; -> IDLE next cycle.
  - A new request arriving in RELEASE is handled from IDLE; no request is lost because the FIFO holds writes.
- Read latency:
  - hs_addr presented in cycle N (GRANT, FIFO empty) -> hs_ra in N+1 -> ram_q in N+2 -> hs_din updated at the edge ending N+2, valid in N+3.
  - hs_din loads only when the cycle-(N+1) access was a read with ram_sel=1. Otherwise it holds its value.
- Write ordering: FIFO order is preserved exactly. A read never overtakes a queued write because reads issue only when the FIFO is empty.
- CPU path: while in REQ, the CPU keeps the RAM (ram_sel=0), so CPU writes still land until grant.

Test Plan:
- Reset, then cpu_addr=0x123, cpu_we=1 -> ram_addr=0x123, ram_we=1 same cycle; ram_sel=0, cpu_pause_req=0.
- hs_pause=1, cpu_idle=1 held -> cpu_pause_req=1 next cycle, ram_sel=1 four cycles after cpu_pause_req; drop hs_pause -> RELEASE, ram_sel=0, cpu_pause_req=0 within 2 cycles.
- Pulse hs_write 3 times in IDLE (addr 0x010/0x011/0x012, data A5/5A/FF), cpu_idle=1 -> after grant, exactly 3 consecutive ram_we cycles in that order, then ram_we=0.
- In GRANT with FIFO empty, RAM model holds 0x3C at 0x200; hs_addr=0x200 at cycle N -> hs_din=0x3C in N+3.
- 9 hs_write pulses with cpu_idle=0 (depth 8) -> fifo_overflow=1, 8 entries drained after cpu_idle rises, 9th absent.
- cpu_idle stuck 0 with TIMEOUT=16 -> forced grant after 16 REQ cycles, grant_timeout=1; assert reset mid-drain -> all outputs 0 next edge, FIFO empty, state IDLE.
